tmds_dec: RTL and testbench



---
 rtl/tmds_dec.sv | 167 ++++++++++++++++
 tb/tb_tmds_dec.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/tmds_dec.sv
// TMDS receive decoder for one lane: control-token word alignment via bitslip, then de/ctrl/data recovery.
// Latency: tmds_i to de_o/ctrl_o/data_o is 2 cycles; locked_o rises together with the first gated output.
// Backpressure: none; one symbol accepted every cycle, bitslip_o asks the deserializer to shift 1 bit.
module tmds_dec #(
  parameter int SEARCH_WINDOW = 4096,
  parameter int CTRL_RUN      = 8,
  parameter int SLIP_WAIT     = 4,
  parameter int MISS_LIMIT    = 2
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic [9:0] tmds_i,
  output logic       bitslip_o,
  output logic       locked_o,
  output logic       de_o,
  output logic [1:0] ctrl_o,
  output logic [7:0] data_o
);

  // Run counter must be able to hold CTRL_RUN itself while saturated.
  localparam int WIN_W  = (SEARCH_WINDOW > 1) ? $clog2(SEARCH_WINDOW) : 1;
  localparam int RUN_W  = $clog2(CTRL_RUN + 1);
  localparam int WAIT_W = (SLIP_WAIT > 1) ? $clog2(SLIP_WAIT) : 1;
  localparam int MISS_W = $clog2(MISS_LIMIT + 1);

  localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(SEARCH_WINDOW - 1);
  localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(CTRL_RUN - 1);
  localparam logic [RUN_W-1:0]  RUN_FULL  = RUN_W'(CTRL_RUN);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SLIP_WAIT - 1);
  localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(MISS_LIMIT - 1);

  typedef enum logic [1:0] {S_SEARCH, S_SLIP, S_WAIT, S_LOCKED} state_t;

  state_t              state;
  state_t              state_nxt;
  logic [WIN_W-1:0]    win_cnt;
  logic [RUN_W-1:0]    run_cnt;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [MISS_W-1:0]   miss_cnt;

  logic                in_is_ctrl;
  logic [1:0]          in_ctrl;
  logic [9:0]          s1_sym;
  logic                s1_is_ctrl;
  logic [1:0]          s1_ctrl;
  logic [7:0]          s1_dec;
  logic [7:0]          s1_d;
  logic                qual;
  logic                win_exp;

  // Classify the incoming word against the four DVI control tokens.
  always_comb begin
    in_is_ctrl = 1'b1;
    in_ctrl    = 2'b00;
    case (tmds_i)
      10'h354: in_ctrl = 2'b00;
      10'h0AB: in_ctrl = 2'b01;
      10'h154: in_ctrl = 2'b10;
      10'h2AB: in_ctrl = 2'b11;
      default: in_is_ctrl = 1'b0;
    endcase
  end

  // Stage 1: register the raw symbol and its classification.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      s1_sym     <= '0;
      s1_is_ctrl <= 1'b0;
      s1_ctrl    <= 2'b00;
    end else begin
      s1_sym     <= tmds_i;
      s1_is_ctrl <= in_is_ctrl;
      s1_ctrl    <= in_ctrl;
    end
  end

  // Undo the optional inversion, then the XOR/XNOR transition chain.
  always_comb begin
    s1_d      = s1_sym[9] ? ~s1_sym[7:0] : s1_sym[7:0];
    s1_dec    = '0;
    s1_dec[0] = s1_d[0];
    for (int i = 1; i < 8; i++) begin
      s1_dec[i] = s1_sym[8] ? (s1_d[i] ^ s1_d[i-1]) : ~(s1_d[i] ^ s1_d[i-1]);
    end
  end

  // A run qualifies once, on the token that brings the count to CTRL_RUN.
  always_comb begin
    qual    = s1_is_ctrl && (run_cnt == RUN_LAST) && (state != S_WAIT);
    win_exp = (win_cnt == WIN_LAST);
  end

  // Next-state decision; a qualified run always beats a window expiry.
  always_comb begin
    state_nxt = state;
    case (state)
      S_SEARCH: begin
        if (qual)         state_nxt = S_LOCKED;
        else if (win_exp) state_nxt = S_SLIP;
      end
      S_SLIP:   state_nxt = S_WAIT;
      S_WAIT: begin
        if (wait_cnt == WAIT_LAST) state_nxt = S_SEARCH;
      end
      S_LOCKED: begin
        if (!qual && win_exp && (miss_cnt == MISS_LAST)) state_nxt = S_SLIP;
      end
      default:  state_nxt = S_SEARCH;
    endcase
  end

  // Alignment FSM with its counters and registered status outputs.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state     <= S_SEARCH;
      win_cnt   <= '0;
      run_cnt   <= '0;
      wait_cnt  <= '0;
      miss_cnt  <= '0;
      bitslip_o <= 1'b0;
      locked_o  <= 1'b0;
    end else begin
      state     <= state_nxt;
      bitslip_o <= (state_nxt == S_SLIP);
      locked_o  <= (state_nxt == S_LOCKED);

      if (state == S_WAIT || !s1_is_ctrl) run_cnt <= '0;
      else if (run_cnt != RUN_FULL)      run_cnt <= run_cnt + 1'b1;

      case (state)
        S_SEARCH, S_LOCKED: begin
          if (qual || win_exp) win_cnt <= '0;
          else                 win_cnt <= win_cnt + 1'b1;
        end
        default: win_cnt <= '0;
      endcase

      if (state == S_LOCKED) begin
        if (qual)         miss_cnt <= '0;
        else if (win_exp) miss_cnt <= miss_cnt + 1'b1;
      end else begin
        miss_cnt <= '0;
      end

      if (state == S_WAIT && wait_cnt != WAIT_LAST) wait_cnt <= wait_cnt + 1'b1;
      else                                          wait_cnt <= '0;
    end
  end

  // Stage 2: decoded outputs, gated by the lock state that takes effect on this edge.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      de_o   <= 1'b0;
      ctrl_o <= 2'b00;
      data_o <= 8'h00;
    end else if (state_nxt == S_LOCKED) begin
      de_o   <= !s1_is_ctrl;
      ctrl_o <= s1_is_ctrl ? s1_ctrl : 2'b00;
      data_o <= s1_is_ctrl ? 8'h00 : s1_dec;
    end else begin
      de_o   <= 1'b0;
      ctrl_o <= 2'b00;
      data_o <= 8'h00;
    end
  end

endmodule

// File: tb/tb_tmds_dec.sv
// Bench for tmds_dec: table-driven vectors through a 2-deep scoreboard, plus slip/reset sequences.
// Expected values come from the stimulus plan and a TMDS encoder model.
// Serial misalignment is modelled by shifting a two-symbol window.
module tb_tmds_dec;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] tmds;
  logic       bitslip, locked, de;
  logic [1:0] ctrl;
  logic [7:0] data;

  always #5 clk = ~clk;

  tmds_dec dut (
    .clk_i(clk), .rst_n_i(rst_n), .tmds_i(tmds),
    .bitslip_o(bitslip), .locked_o(locked), .de_o(de), .ctrl_o(ctrl), .data_o(data)
  );

  typedef struct {
    logic [9:0] sym;
    bit         chk;
    bit         lock;
    bit         slip;
    bit         de;
    logic [1:0] ctrl;
    logic [7:0] data;
  } vec_t;

  localparam logic [9:0] TOK [4] = '{10'h354, 10'h0AB, 10'h154, 10'h2AB};

  vec_t       sb [$];
  vec_t       aligned_tbl [$];
  vec_t       ctrl_tbl [$];
  logic [9:0] line [100];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         enc_cnt = 0;
  bit         seen_slip, seen_lock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at step %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [9:0] sym, input bit chk, input bit lock, input bit slip,
                              input bit de_e, input logic [1:0] c, input logic [7:0] d);
    vec_t v;
    v.sym = sym; v.chk = chk; v.lock = lock; v.slip = slip; v.de = de_e; v.ctrl = c; v.data = d;
    return v;
  endfunction

  // DVI TMDS encoder with running disparity (reset to 0 by the caller on control periods).
  function automatic logic [9:0] encode(input logic [7:0] d);
    logic [8:0] qm;
    logic [9:0] q;
    int n1, n1q, n0q;
    n1 = $countones(d);
    qm[0] = d[0];
    if (n1 > 4 || (n1 == 4 && d[0] == 1'b0)) begin
      for (int i = 1; i < 8; i++) qm[i] = ~(qm[i-1] ^ d[i]);
      qm[8] = 1'b0;
    end else begin
      for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ d[i];
      qm[8] = 1'b1;
    end
    n1q = $countones(qm[7:0]);
    n0q = 8 - n1q;
    if (enc_cnt == 0 || n1q == n0q) begin
      q = {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
      if (qm[8]) enc_cnt += n1q - n0q;
      else       enc_cnt += n0q - n1q;
    end else if ((enc_cnt > 0 && n1q > n0q) || (enc_cnt < 0 && n0q > n1q)) begin
      q = {1'b1, qm[8], ~qm[7:0]};
      enc_cnt += (qm[8] ? 2 : 0) + n0q - n1q;
    end else begin
      q = {1'b0, qm[8], qm[7:0]};
      enc_cnt += (qm[8] ? 0 : -2) + n1q - n0q;
    end
    return q;
  endfunction

  // One cycle: sample outputs, retire the entry driven two cycles ago, drive the next one.
  task automatic step(input vec_t v);
    vec_t e;
    @(negedge clk);
    seen_slip = bitslip;
    seen_lock = locked;
    if (sb.size() == 2) begin
      e = sb.pop_front();
      if (e.chk) begin
        check("locked", {31'd0, locked}, {31'd0, e.lock});
        check("bitslip", {31'd0, bitslip}, {31'd0, e.slip});
        check("de", {31'd0, de}, {31'd0, e.de});
        if (!e.de)          check("ctrl", {30'd0, ctrl}, {30'd0, e.ctrl});
        if (e.de || !e.lock) check("data", {24'd0, data}, {24'd0, e.data});
      end
    end
    tmds = v.sym;
    sb.push_back(v);
    cyc++;
  endtask

  task automatic drain();
    repeat (2) step(mk(10'h000, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 8'h00));
  endtask

  // Reset for 3 cycles with random input; every output must read 0 each cycle.
  task automatic do_reset();
    sb.delete();
    rst_n = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("rst_bitslip", {31'd0, bitslip}, 32'd0);
      check("rst_locked", {31'd0, locked}, 32'd0);
      check("rst_de", {31'd0, de}, 32'd0);
      check("rst_ctrl", {30'd0, ctrl}, 32'd0);
      check("rst_data", {24'd0, data}, 32'd0);
      tmds = 10'($urandom);
    end
    rst_n = 1'b1;
    tmds  = 10'h000;
  endtask

  task automatic apply(input vec_t tbl [$]);
    foreach (tbl[i]) step(tbl[i]);
  endtask

  initial begin
    int n8, found, slips, last_slip, lock_seen, extra_slips, drops, n;
    int o, idx;
    logic [19:0] two;

    rst_n = 1'b0;
    tmds  = 10'h000;

    // Vector tables: aligned lock + byte sweep, then the four control values.
    for (int t = 0; t < 20; t++)
      aligned_tbl.push_back(mk(10'h354, 1'b1, (t >= 7), 1'b0, 1'b0, 2'b00, 8'h00));
    enc_cnt = 0;
    for (int b = 0; b < 256; b++)
      aligned_tbl.push_back(mk(encode(8'(b)), 1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 8'(b)));
    for (int g = 0; g < 4; g++)
      for (int r = 0; r < 10; r++)
        ctrl_tbl.push_back(mk(TOK[g], 1'b1, 1'b1, 1'b0, 1'b0, 2'(g), 8'h00));
    enc_cnt = 0;
    for (int p = 0; p < 100; p++) line[p] = (p < 20) ? 10'h354 : encode(8'(p));

    // Aligned lock, byte decode, control decode, then lock loss on data only.
    do_reset();
    apply(aligned_tbl);
    n8 = 0;
    foreach (ctrl_tbl[i]) begin
      if (i == 7) n8 = cyc;
      step(ctrl_tbl[i]);
    end
    enc_cnt = 0;
    for (int j = 0; j < 8256; j++) begin
      n = cyc - n8;
      if (n < 8192) step(mk(encode(8'(j)), 1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 8'(j)));
      else          step(mk(encode(8'(j)), 1'b1, 1'b0, (n == 8192), 1'b0, 2'b00, 8'h00));
    end
    drain();

    // Reset while locked, then the relock must follow the aligned timing exactly.
    do_reset();
    apply(aligned_tbl);
    drain();
    check("pre_reset_locked", {31'd0, seen_lock}, 32'd1);
    do_reset();
    apply(aligned_tbl);
    drain();

    // Reset while in WAIT after a search-window slip.
    do_reset();
    found = 0;
    n = 0;
    for (int j = 1; j <= 4200 && found == 0; j++) begin
      step(mk(10'h000, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 8'h00));
      if (seen_slip) begin found = 1; n = j; end
    end
    check("first_slip_found", found, 1);
    check("first_slip_step", n, 4096);
    step(mk(10'h000, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 8'h00));
    do_reset();
    apply(aligned_tbl);
    drain();

    // Misaligned stream: 3-bit offset, one bit shifted per bitslip pulse.
    do_reset();
    o = 3; idx = 0; slips = 0; last_slip = 0; lock_seen = 0;
    for (int j = 0; j < 40000 && lock_seen == 0; j++) begin
      two = {line[(idx + 1) % 100], line[idx % 100]};
      two = two >> o;
      step(mk(two[9:0], 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 8'h00));
      idx++;
      if (seen_lock) lock_seen = 1;
      if (seen_slip) begin
        slips++;
        if (slips > 1) check("slip_spacing", cyc - last_slip, 4101);
        last_slip = cyc;
        o++;
        if (o == 10) begin o = 0; idx++; end
      end
    end
    check("misaligned_locked", lock_seen, 1);
    check("slip_count", slips, 7);
    check("lock_soon_after_align", {31'd0, (cyc - last_slip) <= 300}, 32'd1);
    extra_slips = 0; drops = 0;
    for (int j = 0; j < 3000; j++) begin
      two = {line[(idx + 1) % 100], line[idx % 100]};
      two = two >> o;
      step(mk(two[9:0], 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 8'h00));
      idx++;
      if (seen_slip) extra_slips++;
      if (!seen_lock) drops++;
    end
    check("slips_after_lock", extra_slips, 0);
    check("lock_drops_after_lock", drops, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
